// File: rtl/uart_tx_core_if.sv
// Parallel-side and serial-side signals of the UART transmitter.
// master = system-side driver, slave = the transmitter core.
interface uart_tx_core_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] P_DATA;
   logic                  Data_Valid;
   logic                  PAR_EN;
   logic                  PAR_TYP;
   logic                  TX_OUT;
   logic                  busy;

   modport master (
      output P_DATA, Data_Valid, PAR_EN, PAR_TYP,
      input  TX_OUT, busy
   );

   modport slave (
      input  P_DATA, Data_Valid, PAR_EN, PAR_TYP,
      output TX_OUT, busy
   );
endinterface

// File: rtl/uart_tx_core.sv
// UART transmitter: serialises one latched word per frame as
// start bit, LSB-first data, optional parity, one stop bit.
module uart_tx_core #(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 1
) (
   input  logic           CLK,
   input  logic           RST,
   uart_tx_core_if.slave  tx_if
);
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  pen_q, pen_d;
   logic                  par_q, par_d;
   logic                  tx_q, tx_d;
   logic                  busy_q, busy_d;
   logic                  wrap;

   function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d,
                                       input logic odd);
      return (^d) ^ odd;
   endfunction

   assign wrap = (cnt_q == CNT_LAST);

   always_comb begin
      state_d = state_q;
      cnt_d   = wrap ? '0 : cnt_q + CW'(1);
      idx_d   = idx_q;
      data_d  = data_q;
      pen_d   = pen_q;
      par_d   = par_q;
      tx_d    = tx_q;
      busy_d  = busy_q;
      case (state_q)
         IDLE: begin
            cnt_d  = '0;
            tx_d   = 1'b1;
            busy_d = 1'b0;
            if (tx_if.Data_Valid) begin
               state_d = START;
               data_d  = tx_if.P_DATA;
               pen_d   = tx_if.PAR_EN;
               // Parity is fixed at acceptance so later input changes cannot leak in.
               par_d   = parity_bit(tx_if.P_DATA, tx_if.PAR_TYP);
               idx_d   = '0;
               tx_d    = 1'b0;
               busy_d  = 1'b1;
            end
         end
         START: begin
            if (wrap) begin
               state_d = DATA;
               idx_d   = '0;
               tx_d    = data_q[0];
               data_d  = data_q >> 1;
            end
         end
         DATA: begin
            if (wrap) begin
               if (idx_q == IDX_LAST) begin
                  state_d = pen_q ? PARITY : STOP;
                  tx_d    = pen_q ? par_q : 1'b1;
               end else begin
                  idx_d  = idx_q + IW'(1);
                  tx_d   = data_q[0];
                  data_d = data_q >> 1;
               end
            end
         end
         PARITY: begin
            if (wrap) begin
               state_d = STOP;
               tx_d    = 1'b1;
            end
         end
         STOP: begin
            if (wrap) begin
               state_d = IDLE;
               tx_d    = 1'b1;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         pen_q   <= 1'b0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         pen_q   <= pen_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
      end
   end

   // Shift register and parity bit are payload only; no reset needed.
   always_ff @(posedge CLK) begin
      data_q <= data_d;
      par_q  <= par_d;
   end

   assign tx_if.TX_OUT = tx_q;
   assign tx_if.busy   = busy_q;
endmodule

// File: tb/tb_uart_tx_core.sv
// Bench for uart_tx_core: one instance at 1 clock/bit, one at 4 clocks/bit,
// expected line/busy values queued per cycle and compared on the falling edge.
module tb_uart_tx_core;
   typedef struct packed {
      logic tx;
      logic busy;
   } exp_t;

   logic clk;
   logic RST;
   int   checks;
   int   errors;
   exp_t sb[$];

   uart_tx_core_if #(.DATA_WIDTH(8)) if1 ();
   uart_tx_core_if #(.DATA_WIDTH(8)) if4 ();

   uart_tx_core #(.DATA_WIDTH(8), .CLKS_PER_BIT(1)) dut1 (
      .CLK   (clk),
      .RST   (RST),
      .tx_if (if1)
   );

   uart_tx_core #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) dut4 (
      .CLK   (clk),
      .RST   (RST),
      .tx_if (if4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic push_exp(input logic tx, input logic bsy);
      exp_t e;
      e.tx   = tx;
      e.busy = bsy;
      sb.push_back(e);
   endtask

   // Reference frame: start, LSB-first data, optional parity, stop.
   task automatic push_frame(input logic [7:0] d, input logic pen,
                             input logic ptyp, input int cpb);
      logic p;
      p = ptyp;
      for (int i = 0; i < 8; i++) p = p ^ d[i];
      repeat (cpb) push_exp(1'b0, 1'b1);
      for (int i = 0; i < 8; i++) repeat (cpb) push_exp(d[i], 1'b1);
      if (pen) repeat (cpb) push_exp(p, 1'b1);
      repeat (cpb) push_exp(1'b1, 1'b1);
   endtask

   task automatic test_reset();
      RST = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (if1.TX_OUT !== 1'b1) begin
         errors++; $display("FAIL reset_tx1: got %b expected 1", if1.TX_OUT);
      end
      checks++;
      if (if1.busy !== 1'b0) begin
         errors++; $display("FAIL reset_busy1: got %b expected 0", if1.busy);
      end
      checks++;
      if (if4.TX_OUT !== 1'b1) begin
         errors++; $display("FAIL reset_tx4: got %b expected 1", if4.TX_OUT);
      end
      checks++;
      if (if4.busy !== 1'b0) begin
         errors++; $display("FAIL reset_busy4: got %b expected 0", if4.busy);
      end
      RST = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (if1.TX_OUT !== 1'b1 || if1.busy !== 1'b0) begin
         errors++; $display("FAIL idle_after_reset: got tx=%b busy=%b expected tx=1 busy=0",
                            if1.TX_OUT, if1.busy);
      end
   endtask

   task automatic test_frames();
      exp_t e;
      int   k;
      logic pen_t [3] = '{1'b1, 1'b1, 1'b0};
      logic typ_t [3] = '{1'b0, 1'b1, 1'b0};
      for (int c = 0; c < 3; c++) begin
         if1.P_DATA     = 8'hA5;
         if1.PAR_EN     = pen_t[c];
         if1.PAR_TYP    = typ_t[c];
         if1.Data_Valid = 1'b1;
         push_frame(8'hA5, pen_t[c], typ_t[c], 1);
         push_exp(1'b1, 1'b0);
         push_exp(1'b1, 1'b0);
         @(negedge clk);
         if1.Data_Valid = 1'b0;
         k = 0;
         while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (if1.TX_OUT !== e.tx) begin
               errors++; $display("FAIL frame%0d_tx[%0d]: got %b expected %b", c, k, if1.TX_OUT, e.tx);
            end
            checks++;
            if (if1.busy !== e.busy) begin
               errors++; $display("FAIL frame%0d_busy[%0d]: got %b expected %b", c, k, if1.busy, e.busy);
            end
            k++;
            @(negedge clk);
         end
      end
   endtask

   task automatic test_cpb4();
      exp_t e;
      int   k;
      if4.P_DATA     = 8'h00;
      if4.PAR_EN     = 1'b0;
      if4.PAR_TYP    = 1'b0;
      if4.Data_Valid = 1'b1;
      push_frame(8'h00, 1'b0, 1'b0, 4);
      push_exp(1'b1, 1'b0);
      push_exp(1'b1, 1'b0);
      @(negedge clk);
      if4.Data_Valid = 1'b0;
      k = 0;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if (if4.TX_OUT !== e.tx) begin
            errors++; $display("FAIL cpb4_tx[%0d]: got %b expected %b", k, if4.TX_OUT, e.tx);
         end
         checks++;
         if (if4.busy !== e.busy) begin
            errors++; $display("FAIL cpb4_busy[%0d]: got %b expected %b", k, if4.busy, e.busy);
         end
         k++;
         @(negedge clk);
      end
   endtask

   task automatic test_ignore_busy();
      exp_t e;
      int   k;
      if1.P_DATA     = 8'hA5;
      if1.PAR_EN     = 1'b1;
      if1.PAR_TYP    = 1'b0;
      if1.Data_Valid = 1'b1;
      push_frame(8'hA5, 1'b1, 1'b0, 1);
      repeat (3) push_exp(1'b1, 1'b0);
      @(negedge clk);
      if1.Data_Valid = 1'b0;
      k = 0;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if (if1.TX_OUT !== e.tx) begin
            errors++; $display("FAIL ignore_tx[%0d]: got %b expected %b", k, if1.TX_OUT, e.tx);
         end
         checks++;
         if (if1.busy !== e.busy) begin
            errors++; $display("FAIL ignore_busy[%0d]: got %b expected %b", k, if1.busy, e.busy);
         end
         if (k == 4) begin
            if1.P_DATA     = 8'h3C;
            if1.PAR_EN     = 1'b0;
            if1.PAR_TYP    = 1'b1;
            if1.Data_Valid = 1'b1;
         end else begin
            if1.Data_Valid = 1'b0;
         end
         k++;
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int   k;
      if1.P_DATA     = 8'h01;
      if1.PAR_EN     = 1'b0;
      if1.PAR_TYP    = 1'b0;
      if1.Data_Valid = 1'b1;
      push_frame(8'h01, 1'b0, 1'b0, 1);
      push_exp(1'b1, 1'b0);
      push_frame(8'h80, 1'b0, 1'b0, 1);
      push_exp(1'b1, 1'b0);
      push_exp(1'b1, 1'b0);
      @(negedge clk);
      k = 0;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if (if1.TX_OUT !== e.tx) begin
            errors++; $display("FAIL b2b_tx[%0d]: got %b expected %b", k, if1.TX_OUT, e.tx);
         end
         checks++;
         if (if1.busy !== e.busy) begin
            errors++; $display("FAIL b2b_busy[%0d]: got %b expected %b", k, if1.busy, e.busy);
         end
         if (k == 0)  if1.P_DATA = 8'h80;
         if (k >= 11) if1.Data_Valid = 1'b0;
         k++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset_mid_frame();
      exp_t e;
      int   k;
      if1.P_DATA     = 8'hA5;
      if1.PAR_EN     = 1'b0;
      if1.PAR_TYP    = 1'b0;
      if1.Data_Valid = 1'b1;
      push_frame(8'hA5, 1'b0, 1'b0, 1);
      @(negedge clk);
      if1.Data_Valid = 1'b0;
      for (k = 0; k < 4; k++) begin
         e = sb.pop_front();
         checks++;
         if (if1.TX_OUT !== e.tx || if1.busy !== e.busy) begin
            errors++; $display("FAIL rstmid_pre[%0d]: got tx=%b busy=%b expected tx=%b busy=%b",
                               k, if1.TX_OUT, if1.busy, e.tx, e.busy);
         end
         if (k < 3) @(negedge clk);
      end
      sb.delete();
      RST = 1'b1;
      @(negedge clk);
      checks++;
      if (if1.TX_OUT !== 1'b1) begin
         errors++; $display("FAIL rstmid_tx: got %b expected 1", if1.TX_OUT);
      end
      checks++;
      if (if1.busy !== 1'b0) begin
         errors++; $display("FAIL rstmid_busy: got %b expected 0", if1.busy);
      end
      RST = 1'b0;
      @(negedge clk);
      if1.P_DATA     = 8'h55;
      if1.PAR_EN     = 1'b1;
      if1.PAR_TYP    = 1'b1;
      if1.Data_Valid = 1'b1;
      push_frame(8'h55, 1'b1, 1'b1, 1);
      push_exp(1'b1, 1'b0);
      @(negedge clk);
      if1.Data_Valid = 1'b0;
      k = 0;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if (if1.TX_OUT !== e.tx) begin
            errors++; $display("FAIL post_rst_tx[%0d]: got %b expected %b", k, if1.TX_OUT, e.tx);
         end
         checks++;
         if (if1.busy !== e.busy) begin
            errors++; $display("FAIL post_rst_busy[%0d]: got %b expected %b", k, if1.busy, e.busy);
         end
         k++;
         @(negedge clk);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      RST = 1'b1;
      if1.P_DATA = '0; if1.Data_Valid = 1'b0; if1.PAR_EN = 1'b0; if1.PAR_TYP = 1'b0;
      if4.P_DATA = '0; if4.Data_Valid = 1'b0; if4.PAR_EN = 1'b0; if4.PAR_TYP = 1'b0;
      test_reset();
      test_frames();
      test_cpb4();
      test_ignore_busy();
      test_back_to_back();
      test_reset_mid_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
